// File: rtl/timing_sequencer.sv
// Instruction-cycle timing generator: one-hot T0..T7, sequence counter, memory handshake stall.
// Optional interrupt cycle enabled by defining INTR_CYCLE_EN.
module timing_sequencer #(
   parameter int SC_W     = 3,
   parameter int MAX_WAIT = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [7:0]           d,
   input  logic                 i_bit,
   input  logic                 hlt,
   input  logic                 mem_ack,
`ifdef INTR_CYCLE_EN
   input  logic                 ien,
   input  logic                 fgi,
   input  logic                 fgo,
   output logic                 r_cycle,
`endif
   output logic [2**SC_W-1:0]   t,
   output logic [SC_W-1:0]      sc,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 instr_done,
   output logic                 decode_err,
   output logic                 mem_timeout,
   output logic                 running
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALTED} state_t;

   localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

   state_t            r_state, w_next_state;
   logic [SC_W-1:0]   r_sc;
   logic [WAIT_W-1:0] r_wait;
   logic              r_timeout;
   logic              r_r;
   logic              w_run, w_req, w_we, w_stall, w_end_pt, w_done, w_err;
   logic              w_halt_req, w_timeout_hit, w_onehot;

   // NOTE: state lives in always_ff with non-blocking assignments and an async active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_next_state = ST_RUN;
         ST_RUN:    if (w_halt_req || w_timeout_hit) w_next_state = ST_HALTED;
         ST_HALTED: if (start) w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_run = (r_state == ST_RUN);
      t     = '0;
      if (w_run) t[r_sc] = 1'b1;
   end

   // Memory step decode; in an interrupt cycle only T1 touches memory (write of return address).
   always_comb begin
      w_req = 1'b0;
      w_we  = 1'b0;
      if (w_run) begin
         if (r_r) begin
            if (r_sc == SC_W'(1)) begin
               w_req = 1'b1;
               w_we  = 1'b1;
            end
         end else begin
            case (r_sc)
               SC_W'(1): w_req = 1'b1;
               SC_W'(3): w_req = ~d[7] & i_bit;
               SC_W'(4): begin
                  w_req = d[0] | d[1] | d[2] | d[3] | d[5] | d[6];
                  w_we  = d[3] | d[5];
               end
               SC_W'(6): begin
                  w_req = d[6];
                  w_we  = d[6];
               end
               default: ;
            endcase
         end
      end
   end

   assign w_stall  = w_req & ~mem_ack;
   assign w_onehot = (d != 8'h00) && ((d & (d - 8'd1)) == 8'h00);

   assign w_end_pt = r_r ? (r_sc == SC_W'(2))
                         : ((r_sc == SC_W'(3)) & d[7])
                         | ((r_sc == SC_W'(4)) & (d[3] | d[4]))
                         | ((r_sc == SC_W'(5)) & (d[0] | d[1] | d[2] | d[5]))
                         | ((r_sc == SC_W'(6)) & d[6]);

   assign w_done        = w_run & w_end_pt & ~w_stall;
   assign w_err         = w_run & ~r_r & (((r_sc == SC_W'(2)) & ~w_onehot) | (r_sc > SC_W'(6)));
   assign w_halt_req    = w_done & ~r_r & (r_sc == SC_W'(3)) & d[7] & ~i_bit & hlt;
   assign w_timeout_hit = (MAX_WAIT != 0) && w_run && w_stall && (r_wait == WAIT_W'(MAX_WAIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sc      <= '0;
         r_wait    <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (!w_run || w_done || w_err || w_timeout_hit) r_sc <= '0;
         else if (!w_stall)                              r_sc <= r_sc + 1'b1;

         if (!w_run || !w_stall) r_wait <= '0;
         else                    r_wait <= r_wait + 1'b1;

         if (w_timeout_hit) r_timeout <= 1'b1;
      end
   end

`ifdef INTR_CYCLE_EN
   // R sets only at a normal instruction boundary that keeps running; it clears when the R cycle ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                r_r <= 1'b0;
      else if (!w_run)           r_r <= 1'b0;
      else if (w_done && r_r)    r_r <= 1'b0;
      else if (w_done && !w_halt_req && ien && (fgi || fgo)) r_r <= 1'b1;
   end
   assign r_cycle = r_r;
`else
   assign r_r = 1'b0;
`endif

   assign sc          = r_sc;
   assign mem_req     = w_req;
   assign mem_we      = w_we;
   assign instr_done  = w_done;
   assign decode_err  = w_err;
   assign mem_timeout = r_timeout;
   assign running     = w_run;

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed bench for timing_sequencer: inputs driven at the falling edge, outputs sampled 1ns later.
`timescale 1ns/1ps
module tb_timing_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] d = 8'h00;
   logic       i_bit = 1'b0;
   logic       hlt = 1'b0;
   logic       mem_ack = 1'b0;
   logic [7:0] t;
   logic [2:0] sc;
   logic       mem_req, mem_we, instr_done, decode_err, mem_timeout, running;
`ifdef INTR_CYCLE_EN
   logic       r_cycle;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   timing_sequencer #(.SC_W(3), .MAX_WAIT(15)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .d(d), .i_bit(i_bit), .hlt(hlt), .mem_ack(mem_ack),
`ifdef INTR_CYCLE_EN
      .ien(1'b0), .fgi(1'b0), .fgo(1'b0), .r_cycle(r_cycle),
`endif
      .t(t), .sc(sc), .mem_req(mem_req), .mem_we(mem_we), .instr_done(instr_done),
      .decode_err(decode_err), .mem_timeout(mem_timeout), .running(running)
   );

   always #5 clk = ~clk;

   // Observed vector: {t, sc, mem_req, mem_we, instr_done, decode_err, running, mem_timeout}
   logic [16:0] obs;
   assign obs = {t, sc, mem_req, mem_we, instr_done, decode_err, running, mem_timeout};

   function automatic logic [16:0] pk(input logic [7:0] tv, input logic [2:0] scv,
                                      input logic req, input logic we, input logic done,
                                      input logic err, input logic run, input logic tmo);
      return {tv, scv, req, we, done, err, run, tmo};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0; d = 8'h02;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b1;
         else        start = 1'b0;
         #1;
         n_tests++;
         if (obs !== 17'h0) begin
            n_fail++;
            $display("FAIL reset[%0d] got %h exp %h", i, obs, 17'h0);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      #1;
      n_tests++;
      if (obs !== 17'h0) begin
         n_fail++;
         $display("FAIL idle_start got %h exp %h", obs, 17'h0);
      end
   endtask

   task automatic test_add();
      bit          ack [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 0};
      logic [16:0] exp [10];
      exp = '{pk(8'h01,0,0,0,0,0,1,0),
              pk(8'h02,1,1,0,0,0,1,0), pk(8'h02,1,1,0,0,0,1,0), pk(8'h02,1,1,0,0,0,1,0),
              pk(8'h04,2,0,0,0,0,1,0), pk(8'h08,3,0,0,0,0,1,0),
              pk(8'h10,4,1,0,0,0,1,0), pk(8'h10,4,1,0,0,0,1,0), pk(8'h10,4,1,0,0,0,1,0),
              pk(8'h20,5,0,0,1,0,1,0)};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         start = 1'b0; d = 8'h02; i_bit = 1'b0; hlt = 1'b0; mem_ack = ack[i];
         #1;
         n_tests++;
         if (obs !== exp[i]) begin
            n_fail++;
            $display("FAIL add[%0d] got %h exp %h", i, obs, exp[i]);
         end
      end
   endtask

   task automatic test_indirect_sta();
      bit          st  [5] = '{0, 0, 1, 0, 0};
      logic [16:0] exp [5];
      exp = '{pk(8'h01,0,0,0,0,0,1,0), pk(8'h02,1,1,0,0,0,1,0), pk(8'h04,2,0,0,0,0,1,0),
              pk(8'h08,3,1,0,0,0,1,0), pk(8'h10,4,1,1,1,0,1,0)};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         start = st[i]; d = 8'h08; i_bit = 1'b1; hlt = 1'b0; mem_ack = 1'b1;
         #1;
         n_tests++;
         if (obs !== exp[i]) begin
            n_fail++;
            $display("FAIL sta[%0d] got %h exp %h", i, obs, exp[i]);
         end
      end
   endtask

   task automatic test_hlt();
      bit          st  [8] = '{0, 0, 0, 0, 1, 0, 1, 0};
      logic [16:0] exp [8];
      exp = '{pk(8'h01,0,0,0,0,0,1,0), pk(8'h02,1,1,0,0,0,1,0), pk(8'h04,2,0,0,0,0,1,0),
              pk(8'h08,3,0,0,1,0,1,0), 17'h0, 17'h0, 17'h0, pk(8'h01,0,0,0,0,0,1,0)};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         start = st[i]; d = 8'h80; i_bit = 1'b0; hlt = 1'b1; mem_ack = 1'b1;
         #1;
         n_tests++;
         if (obs !== exp[i]) begin
            n_fail++;
            $display("FAIL hlt[%0d] got %h exp %h", i, obs, exp[i]);
         end
      end
   endtask

   task automatic test_bad_decode();
      logic [16:0] exp [3];
      exp = '{pk(8'h02,1,1,0,0,0,1,0), pk(8'h04,2,0,0,0,1,1,0), pk(8'h01,0,0,0,0,0,1,0)};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = 1'b0; d = 8'h06; i_bit = 1'b0; hlt = 1'b0; mem_ack = 1'b1;
         #1;
         n_tests++;
         if (obs !== exp[i]) begin
            n_fail++;
            $display("FAIL bad_decode[%0d] got %h exp %h", i, obs, exp[i]);
         end
      end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         start = 1'b0; d = 8'h02; i_bit = 1'b0; hlt = 1'b0; mem_ack = 1'b0;
         #1;
         n_tests++;
         if (obs !== pk(8'h02,1,1,0,0,0,1,0)) begin
            n_fail++;
            $display("FAIL stall[%0d] got %h exp %h", i, obs, pk(8'h02,1,1,0,0,0,1,0));
         end
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (obs !== pk(8'h00,0,0,0,0,0,0,1)) begin
         n_fail++;
         $display("FAIL timeout_flag got %h exp %h", obs, pk(8'h00,0,0,0,0,0,0,1));
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (obs !== 17'h0) begin
         n_fail++;
         $display("FAIL timeout_clear got %h exp %h", obs, 17'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_isz();
      bit          st  [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
      logic [16:0] exp [9];
      exp = '{17'h0, pk(8'h01,0,0,0,0,0,1,0), pk(8'h02,1,1,0,0,0,1,0), pk(8'h04,2,0,0,0,0,1,0),
              pk(8'h08,3,0,0,0,0,1,0), pk(8'h10,4,1,0,0,0,1,0), pk(8'h20,5,0,0,0,0,1,0),
              pk(8'h40,6,1,1,1,0,1,0), pk(8'h01,0,0,0,0,0,1,0)};
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         start = st[i]; d = 8'h40; i_bit = 1'b0; hlt = 1'b0; mem_ack = 1'b1;
         #1;
         n_tests++;
         if (obs !== exp[i]) begin
            n_fail++;
            $display("FAIL isz[%0d] got %h exp %h", i, obs, exp[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_indirect_sta();
      test_hlt();
      test_bad_decode();
      test_timeout();
      test_isz();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
